// File: rtl/process_scheduler.sv
// Round-robin process scheduler: per-slot saved PC table, quantum preemption and
// registered jump redirects into the OS handler or back into a user process.
module process_scheduler #(
    parameter int ADDR_W          = 12,
    parameter int DATA_W          = 32,
    parameter int NUM_PROC        = 4,
    parameter int PID_W           = 2,
    parameter int DEFAULT_QUANTUM = 500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_sel,
    input  logic [PID_W-1:0]    cfg_pid,
    input  logic [DATA_W-1:0]   cfg_data,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                halt,
    input  logic                stall,
    input  logic                dispatch,
    output logic                redirect,
    output logic [ADDR_W-1:0]   redirect_addr,
    output logic                cs,
    output logic                running,
    output logic [PID_W-1:0]    active_pid,
    output logic [NUM_PROC-1:0] ready_mask,
    output logic                idle
);

    typedef enum logic {ST_OS, ST_RUN} state_t;

    state_t              state, state_next;
    logic [NUM_PROC-1:0] valid;
    logic [ADDR_W-1:0]   saved_pc [NUM_PROC];
    logic [DATA_W-1:0]   quantum, quantum_m1, count;
    logic                multprog;
    logic [ADDR_W-1:0]   os_addr;
    logic [PID_W-1:0]    pick, scan_idx;
    logic                found;
    logic                do_dispatch, do_halt, do_expire;
    logic                redirect_next, cs_next;
    logic [ADDR_W-1:0]   redirect_addr_next;

    assign ready_mask = valid;
    assign idle       = ~|valid;
    assign running    = (state == ST_RUN);
    assign quantum_m1 = (quantum == '0) ? '0 : quantum - DATA_W'(1);

    // Descending scan so the nearest valid slot after active_pid wins; offset
    // NUM_PROC wraps to active_pid itself, re-selecting a lone valid slot.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = NUM_PROC; i >= 1; i--) begin
            scan_idx = active_pid + PID_W'(i);
            if (valid[scan_idx]) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next         = state;
        redirect_next      = 1'b0;
        redirect_addr_next = '0;
        cs_next            = 1'b0;
        do_dispatch        = 1'b0;
        do_halt            = 1'b0;
        do_expire          = 1'b0;
        case (state)
            ST_OS: begin
                if (dispatch && found) begin
                    do_dispatch        = 1'b1;
                    redirect_next      = 1'b1;
                    redirect_addr_next = saved_pc[pick];
                    state_next         = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    do_halt            = 1'b1;
                    redirect_next      = 1'b1;
                    redirect_addr_next = multprog ? os_addr : '0;
                    state_next         = ST_OS;
                end else if (multprog && !stall && count >= quantum_m1) begin
                    do_expire          = 1'b1;
                    cs_next            = 1'b1;
                    redirect_next      = 1'b1;
                    redirect_addr_next = os_addr;
                    state_next         = ST_OS;
                end
            end
            default: state_next = ST_OS;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_OS;
            redirect      <= 1'b0;
            redirect_addr <= '0;
            cs            <= 1'b0;
            active_pid    <= PID_W'(NUM_PROC - 1);
            valid         <= '0;
            quantum       <= DATA_W'(DEFAULT_QUANTUM);
            multprog      <= 1'b0;
            os_addr       <= '0;
            count         <= '0;
            for (int i = 0; i < NUM_PROC; i++) saved_pc[i] <= '0;
        end else begin
            state         <= state_next;
            redirect      <= redirect_next;
            redirect_addr <= redirect_addr_next;
            cs            <= cs_next;
            if (do_dispatch) active_pid <= pick;
            if (do_dispatch || !multprog || (state == ST_RUN && stall)) count <= '0;
            else if (state == ST_RUN) count <= count + DATA_W'(1);
            if (do_halt) valid[active_pid] <= 1'b0;
            if (do_expire) saved_pc[active_pid] <= pc;
            // Config writes come last so they override halt/expiry on the same slot.
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0: quantum  <= cfg_data;
                    2'd1: multprog <= cfg_data[0];
                    2'd2: os_addr  <= cfg_data[ADDR_W-1:0];
                    default: begin
                        saved_pc[cfg_pid] <= cfg_data[ADDR_W-1:0];
                        valid[cfg_pid]    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_process_scheduler.sv
// Self-checking bench for process_scheduler: scenario tasks with random slot PCs,
// quanta and OS addresses, checked against a transaction-level scheduler model.
module tb_process_scheduler;

    logic        clock = 1'b0;
    logic        reset, cfg_we, halt, stall, dispatch;
    logic [1:0]  cfg_sel, cfg_pid, active_pid;
    logic [31:0] cfg_data;
    logic [11:0] pc, redirect_addr;
    logic        redirect, cs, running, idle;
    logic [3:0]  ready_mask;

    int checks = 0;
    int failures = 0;

    // model of scheduler bookkeeping
    bit          m_valid [4];
    logic [11:0] m_pc [4];
    int          m_active, m_q;
    bit          m_mp;
    logic [11:0] m_os;

    process_scheduler dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_pid(cfg_pid), .cfg_data(cfg_data), .pc(pc), .halt(halt),
        .stall(stall), .dispatch(dispatch), .redirect(redirect),
        .redirect_addr(redirect_addr), .cs(cs), .running(running),
        .active_pid(active_pid), .ready_mask(ready_mask), .idle(idle)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_pick();
        for (int i = 1; i <= 4; i++) begin
            int s = (m_active + i) % 4;
            if (m_valid[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_mask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = m_valid[i];
        return m;
    endfunction

    function automatic int model_qeff();
        return (m_q == 0) ? 1 : m_q;
    endfunction

    task automatic reset_dut();
        reset = 1'b1; cfg_we = 1'b0; halt = 1'b0; stall = 1'b0; dispatch = 1'b0;
        cfg_sel = '0; cfg_pid = '0; cfg_data = '0; pc = '0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_pc[i] = '0; end
        m_active = 3; m_q = 500000; m_mp = 0; m_os = '0;
    endtask

    task automatic cfg(input logic [1:0] sel, input int pid, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_pid = 2'(pid); cfg_data = data;
        tick();
        cfg_we = 1'b0;
        case (sel)
            2'd0: m_q = int'(data);
            2'd1: m_mp = data[0];
            2'd2: m_os = data[11:0];
            default: begin m_pc[pid] = data[11:0]; m_valid[pid] = 1; end
        endcase
    endtask

    task automatic pulse_dispatch();
        dispatch = 1'b1;
        tick();
        dispatch = 1'b0;
    endtask

    // Steps until redirect is seen; k = edges stepped, or -1 when the budget runs out.
    task automatic wait_redirect(input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (redirect === 1'b1) begin k = i; break; end
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", redirect); end
        checks++; if (cs !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", cs); end
        checks++; if (redirect_addr !== 12'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", redirect_addr); end
        checks++; if (active_pid !== 2'd3) begin failures++; $display("FAIL reset_pid got=%0d exp=3", active_pid); end
        checks++; if (ready_mask !== 4'b0000 || idle !== 1'b1) begin failures++; $display("FAIL reset_mask got=%b/%b exp=0000/1", ready_mask, idle); end
    endtask

    task automatic test_basic_dispatch();
        int n;
        reset_dut();
        cfg(2'd3, 0, 32'h100);
        cfg(2'd3, 2, 32'h200);
        checks++; if (ready_mask !== 4'b0101 || idle !== 1'b0) begin failures++; $display("FAIL basic_mask got=%b/%b exp=0101/0", ready_mask, idle); end
        pulse_dispatch();
        m_active = 0;
        checks++; if ({redirect, redirect_addr, active_pid, running} !== {1'b1, 12'h100, 2'd0, 1'b1}) begin
            failures++; $display("FAIL basic_dispatch got=%b/%h/%0d/%b exp=1/100/0/1", redirect, redirect_addr, active_pid, running); end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            pc = 12'($urandom);
            tick();
            if (redirect === 1'b1 || cs === 1'b1) n++;
        end
        checks++; if (n !== 0 || running !== 1'b1) begin failures++; $display("FAIL basic_no_preempt got=%0d/%b exp=0/1", n, running); end
        halt = 1'b1; tick(); halt = 1'b0;
        m_valid[0] = 0;
        checks++; if ({redirect, redirect_addr, cs, running} !== {1'b1, 12'h000, 1'b0, 1'b0}) begin
            failures++; $display("FAIL basic_halt_mp0 got=%b/%h/%b/%b exp=1/000/0/0", redirect, redirect_addr, cs, running); end
        checks++; if (ready_mask !== model_mask()) begin failures++; $display("FAIL basic_halt_mask got=%b exp=%b", ready_mask, model_mask()); end
        tick();
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", redirect); end
    endtask

    task automatic test_quantum_rr();
        int p, k, qe;
        logic [11:0] cur;
        for (int phase = 0; phase < 2; phase++) begin
            reset_dut();
            if (phase == 0) begin
                cfg(2'd3, 0, 32'h100);
                cfg(2'd3, 2, 32'h200);
                cfg(2'd0, 0, 32'd5);
                cfg(2'd2, 0, 32'h010);
            end else begin
                for (int s = 0; s < 4; s++) if ($urandom_range(0, 1) == 1) cfg(2'd3, s, 32'($urandom));
                cfg(2'd3, int'($urandom_range(0, 3)), 32'($urandom));
                cfg(2'd0, 0, 32'($urandom_range(0, 9)));
                cfg(2'd2, 0, 32'($urandom));
            end
            cfg(2'd1, 0, 32'd1);
            for (int r = 0; r < 6; r++) begin
                if (phase == 1 && $urandom_range(0, 2) == 0) cfg(2'd0, 0, 32'($urandom_range(0, 9)));
                p = model_pick();
                pulse_dispatch();
                m_active = p;
                checks++; if ({redirect, redirect_addr, active_pid, running} !== {1'b1, m_pc[p], 2'(p), 1'b1}) begin
                    failures++; $display("FAIL rr_dispatch p%0d r%0d got=%b/%h/%0d/%b exp=1/%h/%0d/1", phase, r, redirect, redirect_addr, active_pid, running, m_pc[p], p); end
                cur = (phase == 0 && r == 0) ? 12'h104 : 12'($urandom);
                pc = cur;
                qe = model_qeff();
                wait_redirect(qe + 5, k);
                checks++; if (k !== qe || cs !== 1'b1 || redirect_addr !== m_os || running !== 1'b0) begin
                    failures++; $display("FAIL rr_expiry p%0d r%0d got=k%0d/cs%b/%h/%b exp=k%0d/cs1/%h/0", phase, r, k, cs, redirect_addr, running, qe, m_os); end
                m_pc[p] = cur;
                tick();
            end
        end
    endtask

    task automatic test_stall();
        int k, qe, s, early;
        for (int it = 0; it < 3; it++) begin
            reset_dut();
            cfg(2'd3, 1, 32'($urandom));
            cfg(2'd0, 0, (it == 0) ? 32'd5 : 32'($urandom_range(3, 9)));
            cfg(2'd2, 0, 32'($urandom));
            cfg(2'd1, 0, 32'd1);
            qe = model_qeff();
            s = (it == 0) ? 4 : int'($urandom_range(1, qe - 1));
            pulse_dispatch();
            m_active = 1;
            early = 0;
            for (int i = 1; i < s; i++) begin tick(); if (redirect === 1'b1) early++; end
            stall = 1'b1; tick(); stall = 1'b0;
            if (redirect === 1'b1) early++;
            wait_redirect(qe + 5, k);
            checks++; if (early !== 0 || k !== qe || cs !== 1'b1 || redirect_addr !== m_os) begin
                failures++; $display("FAIL stall_delay it%0d got=early%0d/k%0d/cs%b/%h exp=early0/k%0d/cs1/%h", it, early, k, cs, redirect_addr, qe, m_os); end
        end
    endtask

    task automatic test_halt_expiry();
        int p;
        logic [11:0] fresh;
        reset_dut();
        cfg(2'd3, 0, 32'($urandom));
        cfg(2'd3, 1, 32'($urandom));
        cfg(2'd0, 0, 32'd3);
        cfg(2'd2, 0, 32'($urandom));
        cfg(2'd1, 0, 32'd1);
        pulse_dispatch();
        m_active = 0;
        tick(); tick();
        halt = 1'b1; tick(); halt = 1'b0;
        m_valid[0] = 0;
        checks++; if ({redirect, cs, redirect_addr, running} !== {1'b1, 1'b0, m_os, 1'b0}) begin
            failures++; $display("FAIL halt_vs_expiry got=%b/%b/%h/%b exp=1/0/%h/0", redirect, cs, redirect_addr, running, m_os); end
        checks++; if (ready_mask !== model_mask()) begin failures++; $display("FAIL halt_vs_expiry_mask got=%b exp=%b", ready_mask, model_mask()); end
        p = model_pick();
        pulse_dispatch();
        m_active = p;
        checks++; if (active_pid !== 2'(p) || redirect_addr !== m_pc[p]) begin
            failures++; $display("FAIL halt_next_dispatch got=%0d/%h exp=%0d/%h", active_pid, redirect_addr, p, m_pc[p]); end
        tick();
        fresh = 12'($urandom);
        halt = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd3; cfg_pid = 2'(p); cfg_data = {20'h0, fresh};
        tick();
        halt = 1'b0; cfg_we = 1'b0;
        m_pc[p] = fresh;
        checks++; if (ready_mask !== model_mask() || redirect !== 1'b1 || redirect_addr !== m_os) begin
            failures++; $display("FAIL halt_cfg_wins got=%b/%b/%h exp=%b/1/%h", ready_mask, redirect, redirect_addr, model_mask(), m_os); end
        tick();
        p = model_pick();
        pulse_dispatch();
        checks++; if (active_pid !== 2'(p) || redirect !== 1'b1 || redirect_addr !== fresh) begin
            failures++; $display("FAIL lone_reselect got=%0d/%b/%h exp=%0d/1/%h", active_pid, redirect, redirect_addr, p, fresh); end
    endtask

    task automatic test_idle_quantum_lower();
        int n;
        reset_dut();
        cfg(2'd3, 3, 32'($urandom));
        cfg(2'd0, 0, 32'd1000);
        cfg(2'd2, 0, 32'($urandom));
        cfg(2'd1, 0, 32'd1);
        pulse_dispatch();
        halt = 1'b1; tick(); halt = 1'b0;
        m_valid[3] = 0; m_active = 3;
        checks++; if (idle !== 1'b1 || ready_mask !== 4'b0000) begin failures++; $display("FAIL all_halted got=%b/%b exp=1/0000", idle, ready_mask); end
        tick();
        pulse_dispatch();
        n = (redirect === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin tick(); if (redirect === 1'b1) n++; end
        checks++; if (n !== 0 || running !== 1'b0 || idle !== 1'b1) begin
            failures++; $display("FAIL idle_dispatch got=%0d/%b/%b exp=0/0/1", n, running, idle); end
        cfg(2'd3, 2, 32'($urandom));
        cfg(2'd0, 0, 32'd10);
        pulse_dispatch();
        checks++; if (active_pid !== 2'd2 || redirect_addr !== m_pc[2]) begin
            failures++; $display("FAIL qlow_dispatch got=%0d/%h exp=2/%h", active_pid, redirect_addr, m_pc[2]); end
        n = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (redirect === 1'b1) n++; end
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'd2;
        tick();
        cfg_we = 1'b0;
        if (redirect === 1'b1) n++;
        tick();
        checks++; if (n !== 0 || redirect !== 1'b1 || cs !== 1'b1 || redirect_addr !== m_os) begin
            failures++; $display("FAIL quantum_lowered got=early%0d/%b/%b/%h exp=early0/1/1/%h", n, redirect, cs, redirect_addr, m_os); end
    endtask

    task automatic test_reset_mid_run();
        reset_dut();
        cfg(2'd3, 0, 32'($urandom));
        cfg(2'd0, 0, 32'd3);
        cfg(2'd2, 0, 32'($urandom) | 32'h1);
        cfg(2'd1, 0, 32'd1);
        pulse_dispatch();
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if ({redirect, cs, redirect_addr, running} !== {1'b0, 1'b0, 12'h000, 1'b0}) begin
            failures++; $display("FAIL midrun_reset got=%b/%b/%h/%b exp=0/0/000/0", redirect, cs, redirect_addr, running); end
        checks++; if (active_pid !== 2'd3 || ready_mask !== 4'b0000 || idle !== 1'b1) begin
            failures++; $display("FAIL midrun_reset_state got=%0d/%b/%b exp=3/0000/1", active_pid, ready_mask, idle); end
        tick();
        checks++; if (redirect !== 1'b0 || cs !== 1'b0) begin failures++; $display("FAIL midrun_reset_hold got=%b/%b exp=0/0", redirect, cs); end
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_quantum_rr();
        test_stall();
        test_halt_expiry();
        test_idle_quantum_lower();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
